// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline register, one-cycle latency; ready/valid come from registered state only.
// Optional stall counter under PIPE_STAGE_SKID_STALL_CNT_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, move_skid;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = TWO;
          end else if (out_fire) begin
            state_d   = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            move_skid = 1'b1;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // main keeps its value while idle; skid is only meaningful in TWO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
  sat_counter #(
    .W(16)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid against a queue model.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [39:0] q[$];
  logic [39:0] exp_ent;

  pipe_stage_skid #(
    .DATA_W(32),
    .CTRL_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_data",  out_data,  0);
    check("rst_out_ctrl",  out_ctrl,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back streaming
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h01;
    step();
    check("b2b_vld0", out_valid, 1);
    check("b2b_d0", out_data, 32'h11);
    check("b2b_rdy0", in_ready, 1);
    in_data = 32'h22; in_ctrl = 8'h02;
    step();
    check("b2b_d1", out_data, 32'h22);
    check("b2b_rdy1", in_ready, 1);
    in_data = 32'h33; in_ctrl = 8'h03;
    step();
    check("b2b_d2", out_data, 32'h33);
    check("b2b_c2", out_ctrl, 8'h03);
    check("b2b_rdy2", in_ready, 1);
    in_valid = 1'b0;
    step();
    check("b2b_drain_vld", out_valid, 0);
    check("b2b_drain_ctrl", out_ctrl, 0);

    // fill to TWO, hold third upstream, then drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1; in_ctrl = 8'h10;
    step();
    check("skid_d_a1", out_data, 32'hA1);
    check("skid_rdy_one", in_ready, 1);
    in_data = 32'hA2; in_ctrl = 8'h20;
    step();
    check("skid_rdy_two", in_ready, 0);
    check("skid_hold_a1", out_data, 32'hA1);
    in_data = 32'hA3; in_ctrl = 8'h30;
    step();
    check("skid_rdy_held", in_ready, 0);
    check("skid_still_a1", out_data, 32'hA1);
    out_ready = 1'b1;
    step();
    check("skid_d_a2", out_data, 32'hA2);
    check("skid_c_a2", out_ctrl, 8'h20);
    check("skid_rdy_back", in_ready, 1);
    step();
    check("skid_d_a3", out_data, 32'hA3);
    check("skid_c_a3", out_ctrl, 8'h30);
    in_valid = 1'b0;
    step();
    check("skid_empty", out_valid, 0);

    // flush while full, with a same-cycle offer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1; in_ctrl = 8'h41;
    step();
    in_data = 32'hC2; in_ctrl = 8'h42;
    step();
    check("fl_pre_rdy", in_ready, 0);
    flush = 1'b1; in_data = 32'hBB; in_ctrl = 8'h77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_vld", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_rdy", in_ready, 1);
    check("fl_data", out_data, 0);
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    check("fl_stall_clr", stall_cnt, 0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_bb_absent", out_valid, 0);
    end

    // held control field while stalled
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h5A;
    step();
    in_valid = 1'b0;
    check("ctl_first", out_ctrl, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ctl_steady", out_ctrl, 8'h5A);
    end
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    check("ctl_stall3", stall_cnt, 3);
`endif
    out_ready = 1'b1;
    step();
    check("ctl_drain", out_valid, 0);

    // asynchronous reset while holding one entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99; in_ctrl = 8'h09;
    step();
    in_valid = 1'b0;
    check("ar_pre_vld", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld", out_valid, 0);
    check("ar_rdy", in_ready, 1);
    check("ar_data", out_data, 0);
    check("ar_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    check("ar_stall", stall_cnt, 0);
`endif
    step();
    rst_n = 1'b1;
    check("ar_post_vld", out_valid, 0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h44; in_ctrl = 8'h04;
    step();
    in_valid = 1'b0;
    check("ar_first_vld", out_valid, 1);
    check("ar_first_d", out_data, 32'h44);
    step();
    check("ar_first_gone", out_valid, 0);

    // random traffic against a queue model, last cycles drain
    for (int i = 0; i < 10004; i++) begin
      check("rnd_vld", out_valid, (q.size() != 0));
      check("rnd_rdy", in_ready, (q.size() < 2));
      if (i < 10000) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = $urandom;
        in_ctrl   = 8'($urandom_range(0, 255));
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && (q.size() > 0)) begin
        exp_ent = q.pop_front();
        check("rnd_data", out_data, exp_ent[31:0]);
        check("rnd_ctrl", out_ctrl, {24'h0, exp_ent[39:32]});
      end
      if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
      step();
    end
    check("rnd_model_empty", q.size(), 0);
    check("rnd_dut_empty", out_valid, 0);

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_clr", stall_cnt, 0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5; in_ctrl = 8'h5;
    step();
    in_valid = 1'b0;
    repeat (32'h10004) step();
    check("sat_ffff", stall_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
